// File: rtl/sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_fetch : walks one TILE_W x TILE_H frame of a sprite-sheet ROM and     |
// |                streams its pixels with a valid/ready handshake.             |
// | Optional     : SPRITE_FETCH_KEY_EN builds the transparent-key comparator.    |
// | Revision     : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sprite_fetch #(
  parameter int         SHEET_W   = 256,
  parameter int         TILE_W    = 32,
  parameter int         TILE_H    = 32,
  parameter int         ADDR_W    = 20,
  parameter logic [7:0] KEY_COLOR = 8'h00,
  localparam int        COL_W     = $clog2(SHEET_W / TILE_W),
  localparam int        XW        = $clog2(TILE_W),
  localparam int        YW        = $clog2(TILE_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [COL_W-1:0]  frame_col,
  input  logic [3:0]        frame_row,
  input  logic              flip_x,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] R_ADDR,
  input  logic [7:0]        rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_opaque
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [XW-1:0] c_X_MAX = XW'(TILE_W - 1);
  localparam logic [YW-1:0] c_Y_MAX = YW'(TILE_H - 1);

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  logic [3:0]       r_row;
  logic             r_flip;
  logic [XW-1:0]    r_x, r_iss_x, r_rd_x;
  logic [YW-1:0]    r_y, r_iss_y, r_rd_y;
  logic             r_iss, r_rd;
  logic [7:0]       r_fd [2];
  logic [XW-1:0]    r_fx [2];
  logic [YW-1:0]    r_fy [2];
  logic             r_wp, r_rp;
  logic [1:0]       r_fcnt;

  logic             w_pop, w_out_free, w_from_fifo, w_ld, w_push, w_fpop;
  logic             w_room, w_last, w_ld_opq;
  logic [2:0]       w_owned;
  logic [7:0]       w_ld_data;
  logic [XW-1:0]    w_ld_x;
  logic [YW-1:0]    w_ld_y;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [COL_W-1:0] col,
                                               input logic [3:0] row, input logic flip,
                                               input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [XW-1:0] sx;
    sx = flip ? ~x : x;
    return (ADDR_W'(row) * ADDR_W'(TILE_H) + ADDR_W'(y)) * ADDR_W'(SHEET_W)
           + ADDR_W'(col) * ADDR_W'(TILE_W) + ADDR_W'(sx);
  endfunction

  // Every issued read owns a slot (output register + 2-entry buffer) until it leaves,
  // so a stall can never overflow the buffer while the two-stage read is in flight.
  assign w_pop       = pix_valid & pix_ready;
  assign w_out_free  = ~pix_valid | w_pop;
  assign w_owned     = {2'b00, pix_valid} + {1'b0, r_fcnt} + {2'b00, r_rd} + {2'b00, r_iss};
  assign w_room      = (w_owned - {2'b00, w_pop}) < 3'd3;
  assign w_last      = (w_owned == 3'd1) & w_pop;
  assign w_from_fifo = (r_fcnt != 2'd0);
  assign w_ld        = w_out_free & (w_from_fifo | r_rd);
  assign w_push      = r_rd & ~(w_out_free & ~w_from_fifo);
  assign w_fpop      = w_out_free & w_from_fifo;
  assign w_ld_data   = w_from_fifo ? r_fd[r_rp] : rom_data;
  assign w_ld_x      = w_from_fifo ? r_fx[r_rp] : r_rd_x;
  assign w_ld_y      = w_from_fifo ? r_fy[r_rp] : r_rd_y;
`ifdef SPRITE_FETCH_KEY_EN
  assign w_ld_opq    = (w_ld_data != KEY_COLOR);
`else
  assign w_ld_opq    = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      R_ADDR  <= '0;
      r_iss   <= 1'b0;
      r_iss_x <= '0;
      r_iss_y <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_flip  <= 1'b0;
    end else begin
      done  <= 1'b0;
      r_iss <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The origin read goes out on the accepting edge itself.
          if (start) begin
            r_col   <= frame_col;
            r_row   <= frame_row;
            r_flip  <= flip_x;
            R_ADDR  <= f_addr(frame_col, frame_row, flip_x, '0, '0);
            r_iss   <= 1'b1;
            r_iss_x <= '0;
            r_iss_y <= '0;
            r_x     <= XW'(1);
            r_y     <= '0;
            busy    <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_room) begin
            R_ADDR  <= f_addr(r_col, r_row, r_flip, r_x, r_y);
            r_iss   <= 1'b1;
            r_iss_x <= r_x;
            r_iss_y <= r_y;
            r_x     <= r_x + XW'(1);
            if (r_x == c_X_MAX) begin
              if (r_y == c_Y_MAX) r_state <= S_DRAIN;
              else                r_y     <= r_y + YW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd       <= 1'b0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_fcnt     <= 2'd0;
      pix_valid  <= 1'b0;
      pix_data   <= 8'h00;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_opaque <= 1'b0;
    end else begin
      r_rd   <= r_iss;
      r_rd_x <= r_iss_x;
      r_rd_y <= r_iss_y;
      if (w_out_free) begin
        pix_valid <= w_ld;
        if (w_ld) begin
          pix_data   <= w_ld_data;
          pix_x      <= w_ld_x;
          pix_y      <= w_ld_y;
          pix_opaque <= w_ld_opq;
        end else begin
          pix_opaque <= 1'b0;
        end
      end
      if (w_push) begin
        r_fd[r_wp] <= rom_data;
        r_fx[r_wp] <= r_rd_x;
        r_fy[r_wp] <= r_rd_y;
        r_wp       <= ~r_wp;
      end
      if (w_fpop) r_rp <= ~r_rp;
      r_fcnt <= r_fcnt + {1'b0, w_push} - {1'b0, w_fpop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// tb_sprite_fetch: randomized self-checking bench for sprite_fetch against a raster-walk model.
module tb_sprite_fetch;
  localparam int SW = 256, TW = 32, TH = 32, AW = 20, NPIX = TW * TH;
`ifdef SPRITE_FETCH_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, flip_x = 1'b0, pix_ready = 1'b0;
  logic [2:0]    frame_col = '0;
  logic [3:0]    frame_row = '0;
  logic          busy, done, pix_valid, pix_opaque;
  logic [AW-1:0] R_ADDR;
  logic [7:0]    rom_data, pix_data;
  logic [4:0]    pix_x, pix_y;

  int n_checks = 0, n_pass = 0;

  logic [7:0]    q_d[$];
  logic [4:0]    q_x[$], q_y[$];
  logic          q_o[$];
  logic [AW-1:0] q_a[$];
  int   g_first_lat, g_first_k, g_last_k, g_done_n, g_done_gap, g_stall_viol, g_extra;
  bit   g_timeout, g_restart;
  logic g_busy_at_done;
  logic [2:0] g_ncol;
  logic [3:0] g_nrow;
  logic       g_nflip;

  sprite_fetch dut (
    .Clk(clk), .Reset(rst), .start(start), .frame_col(frame_col), .frame_row(frame_row),
    .flip_x(flip_x), .busy(busy), .done(done), .R_ADDR(R_ADDR), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x),
    .pix_y(pix_y), .pix_opaque(pix_opaque)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a * 20'd157;
    return m[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) rom_data <= rom_word(R_ADDR);

  function automatic logic [AW-1:0] exp_addr(input int col, input int row, input bit fl, input int i);
    int x, y, sx;
    longint a;
    x  = i % TW;
    y  = i / TW;
    sx = fl ? TW - 1 - x : x;
    a  = longint'(row * TH + y) * SW + col * TW + sx;
    return a[AW-1:0];
  endfunction

  function automatic logic exp_opq(input logic [7:0] d);
    return (d != 8'h00) || !KEY_EN;
  endfunction

  function automatic int count_bad(input int col, input int row, input bit fl, output int first);
    int bad;
    bad   = 0;
    first = -1;
    for (int i = 0; i < q_d.size() && i < NPIX; i++) begin
      logic [7:0] d;
      d = rom_word(exp_addr(col, row, fl, i));
      if (q_d[i] !== d || q_x[i] !== 5'(i % TW) || q_y[i] !== 5'(i / TW) || q_o[i] !== exp_opq(d)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    return bad;
  endfunction

  task automatic run_fetch(input logic [2:0] col, input logic [3:0] row, input logic fl, input int mode,
                           input int pulse_k, input int abort_beats, input bit prestarted);
    int k, beats, lowcnt, post;
    bit stalled, low_done, fin, seen_done;
    logic [7:0] sd;
    logic [4:0] sx, sy;
    logic so;
    q_d.delete(); q_x.delete(); q_y.delete(); q_o.delete(); q_a.delete();
    g_first_lat = -1; g_first_k = -1; g_last_k = 0; g_done_n = 0; g_done_gap = -1;
    g_stall_viol = 0; g_extra = 0; g_timeout = 0; g_busy_at_done = 1'bx;
    k = 0; beats = 0; lowcnt = 0; post = 0;
    stalled = 0; low_done = 0; fin = 0; seen_done = 0;
    sd = '0; sx = '0; sy = '0; so = 1'b0;
    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1; frame_col = col; frame_row = row; flip_x = fl;
    end
    while (!fin) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0; frame_col = 3'($urandom); frame_row = 4'($urandom); flip_x = 1'($urandom);
      end
      if (k == pulse_k) begin
        start = 1'b1; frame_col = ~col;
      end else if (pulse_k > 0 && k == pulse_k + 1) begin
        start = 1'b0;
      end
      q_a.push_back(R_ADDR);
      if (stalled && (pix_valid !== 1'b1 || pix_data !== sd || pix_x !== sx || pix_y !== sy || pix_opaque !== so))
        g_stall_viol++;
      if (seen_done) begin
        if (pix_valid === 1'b1 || busy === 1'b1) g_extra++;
        post++;
        if (post == 4) fin = 1;
      end
      if (done === 1'b1) begin
        g_done_n++;
        g_done_gap = k - g_last_k;
        g_busy_at_done = busy;
      end
      if (mode == 0) pix_ready = 1'b1;
      else if (beats >= TW + 16 && !low_done) begin
        pix_ready = 1'b0;
        lowcnt++;
        if (lowcnt == 20) low_done = 1;
      end else pix_ready = 1'($urandom_range(0, 1));
      if (pix_valid === 1'b1 && g_first_lat < 0) g_first_lat = k - 1;
      if (pix_valid === 1'b1 && pix_ready) begin
        q_d.push_back(pix_data); q_x.push_back(pix_x); q_y.push_back(pix_y); q_o.push_back(pix_opaque);
        beats++;
        if (g_first_k < 0) g_first_k = k;
        g_last_k = k;
      end
      stalled = (pix_valid === 1'b1) && !pix_ready;
      sd = pix_data; sx = pix_x; sy = pix_y; so = pix_opaque;
      if (abort_beats > 0 && beats == abort_beats) fin = 1;
      if (done === 1'b1 && !seen_done) begin
        seen_done = 1;
        if (g_restart) begin
          start = 1'b1; frame_col = g_ncol; frame_row = g_nrow; flip_x = g_nflip;
          fin = 1;
        end
      end
      if (k >= 8000) begin
        g_timeout = 1;
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, pix_valid, pix_opaque} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, pix_valid, pix_opaque});
    else n_pass++;
    n_checks++;
    if ({R_ADDR, pix_data, pix_x, pix_y} !== '0)
      $display("FAIL reset_data: got addr=%0d data=%0h x=%0d y=%0d expected all 0", R_ADDR, pix_data, pix_x, pix_y);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_raster();
    int bad, first, abad;
    g_restart = 0;
    run_fetch(3'd1, 4'd0, 1'b0, 0, 0, 0, 0);
    n_checks++; if (g_timeout) $display("FAIL raster_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (q_d.size() !== NPIX) $display("FAIL raster_beats: got %0d expected %0d", q_d.size(), NPIX); else n_pass++;
    bad = count_bad(1, 0, 0, first);
    n_checks++; if (bad !== 0) $display("FAIL raster_content: got %0d bad beats (first %0d) expected 0", bad, first); else n_pass++;
    n_checks++; if (g_first_lat !== 2) $display("FAIL raster_latency: got %0d expected 2", g_first_lat); else n_pass++;
    n_checks++; if (g_last_k - g_first_k !== NPIX - 1) $display("FAIL raster_bubbles: got span %0d expected %0d", g_last_k - g_first_k, NPIX - 1); else n_pass++;
    n_checks++; if (g_done_n !== 1 || g_done_gap !== 1) $display("FAIL raster_done: got count=%0d gap=%0d expected 1/1", g_done_n, g_done_gap); else n_pass++;
    n_checks++; if (g_busy_at_done !== 1'b0) $display("FAIL raster_busy_at_done: got %b expected 0", g_busy_at_done); else n_pass++;
    abad = 0;
    for (int i = 0; i <= 32; i++)
      if (i >= q_a.size() || q_a[i] !== exp_addr(1, 0, 0, i)) abad++;
    n_checks++; if (abad !== 0) $display("FAIL raster_addr_seq: got %0d wrong addresses expected 0", abad); else n_pass++;
    n_checks++;
    if (q_a.size() < NPIX || q_a[NPIX-1] !== 20'd7999)
      $display("FAIL raster_last_addr: got %0d expected 7999", (q_a.size() < NPIX) ? -1 : int'(q_a[NPIX-1]));
    else n_pass++;
    n_checks++; if (g_extra !== 0) $display("FAIL raster_idle_after: got %0d busy/valid cycles expected 0", g_extra); else n_pass++;
  endtask

  task automatic test_flip();
    int bad, first;
    g_restart = 0;
    run_fetch(3'd0, 4'd2, 1'b1, 0, 0, 0, 0);
    n_checks++;
    if (q_a.size() < 32 || q_d.size() < 32 || q_a[0] !== 20'd16415 || q_x[0] !== 5'd0)
      $display("FAIL flip_first: got addr=%0d x=%0d expected 16415/0", q_a.size() ? int'(q_a[0]) : -1, q_x.size() ? int'(q_x[0]) : -1);
    else n_pass++;
    n_checks++;
    if (q_a.size() < 32 || q_d.size() < 32 || q_a[31] !== 20'd16384 || q_x[31] !== 5'd31)
      $display("FAIL flip_beat31: got addr=%0d x=%0d expected 16384/31", q_a.size() >= 32 ? int'(q_a[31]) : -1, q_x.size() >= 32 ? int'(q_x[31]) : -1);
    else n_pass++;
    bad = count_bad(0, 2, 1, first);
    n_checks++; if (bad !== 0 || q_d.size() !== NPIX) $display("FAIL flip_content: got %0d bad of %0d beats expected 0 of %0d", bad, q_d.size(), NPIX); else n_pass++;
  endtask

  task automatic test_random_ready();
    int bad, first;
    logic [2:0] col;
    logic [3:0] row;
    logic fl;
    col = 3'($urandom); row = 4'($urandom); fl = 1'($urandom);
    g_restart = 0;
    run_fetch(col, row, fl, 1, 100, 0, 0);
    n_checks++; if (g_timeout) $display("FAIL rand_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (q_d.size() !== NPIX) $display("FAIL rand_beats: got %0d expected %0d", q_d.size(), NPIX); else n_pass++;
    bad = count_bad(col, row, fl, first);
    n_checks++; if (bad !== 0) $display("FAIL rand_content: got %0d bad beats (first %0d) expected 0", bad, first); else n_pass++;
    n_checks++; if (g_stall_viol !== 0) $display("FAIL rand_stall_stable: got %0d violations expected 0", g_stall_viol); else n_pass++;
    n_checks++; if (g_done_n !== 1 || g_done_gap !== 1) $display("FAIL rand_done: got count=%0d gap=%0d expected 1/1", g_done_n, g_done_gap); else n_pass++;
    n_checks++; if (g_extra !== 0) $display("FAIL rand_no_queue: got %0d busy/valid cycles expected 0", g_extra); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad, first;
    logic [2:0] col;
    logic [3:0] row;
    logic fl;
    col = 3'($urandom); row = 4'($urandom); fl = 1'($urandom);
    g_ncol = ~col; g_nrow = 4'($urandom); g_nflip = ~fl;
    g_restart = 1;
    run_fetch(col, row, fl, 0, 100, 0, 0);
    g_restart = 0;
    bad = count_bad(col, row, fl, first);
    n_checks++;
    if (g_timeout || q_d.size() !== NPIX || bad !== 0 || g_done_n !== 1)
      $display("FAIL b2b_first: got beats=%0d bad=%0d done=%0d expected %0d/0/1", q_d.size(), bad, g_done_n, NPIX);
    else n_pass++;
    run_fetch(g_ncol, g_nrow, g_nflip, 0, 0, 0, 1);
    n_checks++; if (g_first_lat !== 2) $display("FAIL b2b_latency: got %0d expected 2", g_first_lat); else n_pass++;
    bad = count_bad(g_ncol, g_nrow, g_nflip, first);
    n_checks++;
    if (g_timeout || q_d.size() !== NPIX || bad !== 0)
      $display("FAIL b2b_second: got beats=%0d bad=%0d expected %0d/0", q_d.size(), bad, NPIX);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int bad, first;
    g_restart = 0;
    run_fetch(3'd2, 4'd1, 1'b0, 1, 0, 500, 0);
    n_checks++; if (q_d.size() !== 500) $display("FAIL mreset_pre: got %0d beats expected 500", q_d.size()); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pix_valid, pix_opaque} !== 4'b0000 || {R_ADDR, pix_data, pix_x, pix_y} !== '0)
      $display("FAIL mreset_outputs: got ctrl=%b addr=%0d data=%0h x=%0d y=%0d expected all 0",
               {busy, done, pix_valid, pix_opaque}, R_ADDR, pix_data, pix_x, pix_y);
    else n_pass++;
    rst = 1'b0;
    run_fetch(3'd2, 4'd1, 1'b0, 1, 0, 0, 0);
    bad = count_bad(2, 1, 0, first);
    n_checks++;
    if (g_timeout || q_d.size() !== NPIX || bad !== 0 || g_first_lat !== 2)
      $display("FAIL mreset_refetch: got beats=%0d bad=%0d lat=%0d expected %0d/0/2", q_d.size(), bad, g_first_lat, NPIX);
    else n_pass++;
  endtask

  task automatic test_opaque();
    int bad, first;
    g_restart = 0;
    run_fetch(3'd0, 4'd0, 1'b0, 0, 0, 0, 0);
    n_checks++;
    if (q_d.size() < 1 || q_d[0] !== 8'h00 || q_o[0] !== !KEY_EN)
      $display("FAIL opaque_beat0: got data=%0h opq=%0b expected 00/%0b", q_d.size() ? q_d[0] : 8'hxx, q_o.size() ? q_o[0] : 1'bx, !KEY_EN);
    else n_pass++;
    bad = count_bad(0, 0, 0, first);
    n_checks++; if (bad !== 0 || q_d.size() !== NPIX) $display("FAIL opaque_stream: got %0d bad of %0d beats expected 0", bad, q_d.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_raster();
    test_flip();
    test_random_ready();
    test_back_to_back();
    test_mid_reset();
    test_opaque();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
